// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, ALU op codes, bundle bit positions and PC-select codes for the pipeline control unit.
// Pure constants and types; no logic, no latency, no flow control.
package pipe_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'b000,
      ALU_SUB   = 3'b001,
      ALU_FUNCT = 3'b010,
      ALU_AND   = 3'b011,
      ALU_OR    = 3'b100
   } aluop_e;

   // ex bundle: {regdst, alusrc, aluop[2:0], branch, bne, memread}
   localparam int EX_REGDST   = 7;
   localparam int EX_ALUSRC   = 6;
   localparam int EX_ALUOP_HI = 5;
   localparam int EX_ALUOP_LO = 3;
   localparam int EX_BRANCH   = 2;
   localparam int EX_BNE      = 1;
   localparam int EX_MEMREAD  = 0;

   localparam int MEM_MEMREAD  = 1;
   localparam int MEM_MEMWRITE = 0;

   localparam int WB_MEMTOREG = 1;
   localparam int WB_REGWRITE = 0;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef struct packed {
      logic [7:0] ex;
      logic [1:0] mem;
      logic [1:0] wb;
   } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder: ID-stage fields to control bundle, destination register and rt-usage flag; purely combinational.
// No state and no flow control; invalid or unknown opcodes decode as a bubble.
module ctrl_decode
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter bit EXT_OPS_EN = 1'b1
) (
   input  logic              valid,
   input  logic [5:0]        op,
   input  logic [5:0]        funct,
   input  logic [REG_AW-1:0] rt,
   input  logic [REG_AW-1:0] rd,
   output ctrl_t             ctrl,
   output logic [REG_AW-1:0] dst,
   output logic              uses_rt,
   output logic              jump
);

   logic wr;
   // The ALU sub-decodes funct itself; only the opcode matters here.
   logic unused_funct;
   assign unused_funct = ^funct;

   always_comb begin
      ctrl    = '0;
      dst     = '0;
      uses_rt = 1'b0;
      jump    = 1'b0;
      wr      = 1'b0;
      if (valid) begin
         case (op)
            OP_RTYPE: begin
               ctrl.ex[EX_REGDST] = 1'b1;
               ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO] = ALU_FUNCT;
               wr      = 1'b1;
               dst     = rd;
               uses_rt = 1'b1;
            end
            OP_LW: begin
               ctrl.ex[EX_ALUSRC]    = 1'b1;
               ctrl.ex[EX_MEMREAD]   = 1'b1;
               ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO] = ALU_ADD;
               ctrl.mem[MEM_MEMREAD] = 1'b1;
               ctrl.wb[WB_MEMTOREG]  = 1'b1;
               wr  = 1'b1;
               dst = rt;
            end
            OP_SW: begin
               ctrl.ex[EX_ALUSRC]     = 1'b1;
               ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO] = ALU_ADD;
               ctrl.mem[MEM_MEMWRITE] = 1'b1;
               uses_rt = 1'b1;
            end
            OP_BEQ: begin
               ctrl.ex[EX_BRANCH] = 1'b1;
               ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO] = ALU_SUB;
               uses_rt = 1'b1;
            end
            OP_BNE: begin
               if (EXT_OPS_EN) begin
                  ctrl.ex[EX_BRANCH] = 1'b1;
                  ctrl.ex[EX_BNE]    = 1'b1;
                  ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO] = ALU_SUB;
                  uses_rt = 1'b1;
               end
            end
            OP_J: begin
               if (EXT_OPS_EN) jump = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
               if (EXT_OPS_EN) begin
                  ctrl.ex[EX_ALUSRC] = 1'b1;
                  if (op == OP_ADDI)
                     ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO] = ALU_ADD;
                  else if (op == OP_ANDI)
                     ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO] = ALU_AND;
                  else
                     ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO] = ALU_OR;
                  wr  = 1'b1;
                  dst = rt;
               end
            end
            default: ;
         endcase
      end
      // Writes to $0 are architecturally dead; dropping them also keeps forwarding honest.
      ctrl.wb[WB_REGWRITE] = wr & (dst != '0);
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: decode in ID, carry bundles through ID/EX, EX/MEM, MEM/WB (1/2/3 cycles), load-use stall and branch/jump squash.
// hold freezes every register and counter; a load-use hazard holds PC and IF/ID for one cycle via stall.
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter bit HAZARD_EN  = 1'b1,
   parameter bit EXT_OPS_EN = 1'b1,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              id_valid,
   input  logic [5:0]        id_op,
   input  logic [5:0]        id_funct,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              ex_take,
   output logic              stall,
   output logic              flush_if,
   output logic [1:0]        pc_sel,
   output logic [7:0]        ex_ctrl,
   output logic [1:0]        mem_ctrl,
   output logic [1:0]        wb_ctrl,
   output logic [REG_AW-1:0] ex_dst,
   output logic [REG_AW-1:0] mem_dst,
   output logic [REG_AW-1:0] wb_dst,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   ctrl_t             id_ctrl;
   logic [REG_AW-1:0] id_dst;
   logic              id_uses_rt;
   logic              id_jump;

   ctrl_decode #(
      .REG_AW     (REG_AW),
      .EXT_OPS_EN (EXT_OPS_EN)
   ) u_decode (
      .valid   (id_valid),
      .op      (id_op),
      .funct   (id_funct),
      .rt      (id_rt),
      .rd      (id_rd),
      .ctrl    (id_ctrl),
      .dst     (id_dst),
      .uses_rt (id_uses_rt),
      .jump    (id_jump)
   );

   ctrl_t      idex_q;
   logic [1:0] exmem_wb_q;
   logic       br_taken;
   logic       load_use;
   logic       bubble;
   logic       stall_evt;
   logic       flush_evt;

   assign ex_ctrl  = idex_q.ex;
   assign br_taken = ex_take & idex_q.ex[EX_BRANCH];
   assign load_use = HAZARD_EN && id_valid && idex_q.ex[EX_MEMREAD] && (ex_dst != '0) &&
                     ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));

   // Priority: hold, taken branch, load-use stall, jump.
   always_comb begin
      stall     = 1'b0;
      flush_if  = 1'b0;
      pc_sel    = PC_SEQ;
      bubble    = 1'b0;
      stall_evt = 1'b0;
      flush_evt = 1'b0;
      if (rst_n) begin
         if (hold) begin
            stall = 1'b1;
         end else if (br_taken) begin
            pc_sel    = PC_BRANCH;
            flush_if  = 1'b1;
            bubble    = 1'b1;
            flush_evt = 1'b1;
         end else if (load_use) begin
            stall     = 1'b1;
            bubble    = 1'b1;
            stall_evt = 1'b1;
         end else if (id_jump) begin
            pc_sel    = PC_JUMP;
            flush_if  = 1'b1;
            bubble    = 1'b1;
            flush_evt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex_q     <= '0;
         ex_dst     <= '0;
         mem_ctrl   <= '0;
         exmem_wb_q <= '0;
         mem_dst    <= '0;
         wb_ctrl    <= '0;
         wb_dst     <= '0;
      end else if (!hold) begin
         if (bubble) begin
            idex_q <= '0;
            ex_dst <= '0;
         end else begin
            idex_q <= id_ctrl;
            ex_dst <= id_dst;
         end
         mem_ctrl   <= idex_q.mem;
         exmem_wb_q <= idex_q.wb;
         mem_dst    <= ex_dst;
         wb_ctrl    <= exmem_wb_q;
         wb_dst     <= mem_dst;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (!hold) begin
         if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule
